// File: rtl/opb_register_simulink2ppc_status_pkg.sv
// rtl/opb_register_simulink2ppc_status_pkg.sv - Register offsets, STATUS bits and bus FSM states
// Purpose: shared definitions for the simulink2ppc status register slice.
// Contents: word offsets within the 256-byte window, STATUS bit indices and
// the OPB slave FSM state type.
package opb_register_simulink2ppc_status_pkg;

  // Word offsets, taken from OPB_ABus[28:29] (byte offsets 0x0/0x4/0x8/0xC)
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS bit indices (numeric bit positions, bit 0 = LSB)
  localparam int STATUS_NEW_BIT = 0;
  localparam int STATUS_OVF_BIT = 1;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_DECODE = 2'd1,
    BUS_ACK    = 2'd2,
    BUS_HOLD   = 2'd3
  } bus_state_e;

endpackage

// File: rtl/opb_register_simulink2ppc_status_opb_slave_attach.sv
// rtl/opb_register_simulink2ppc_status_opb_slave_attach.sv - OPB window decode and transfer FSM
// Purpose: decodes the address window and sequences IDLE/DECODE/ACK/HOLD.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   abus_i, dbus_i       OPB address / write data, bit 0 = MSB
//   be_lsb_i             OPB_BE[3], enable for the least significant byte
//   rnw_i, select_i      OPB read-not-write and transfer request
//   offset_o, rnw_o      registered word offset and direction of the transfer
//   wdata_o, be_lsb_o    registered write data (numeric order) and byte enable
//   commit_o             one-cycle strobe in DECODE; register updates land on its edge
//   ack_o                high for the single ACK cycle
module opb_register_simulink2ppc_status_opb_slave_attach
  import opb_register_simulink2ppc_status_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0100_1200,
  parameter logic [31:0] C_HIGHADDR = 32'h0100_12FF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [0:31] abus_i,
  input  logic [0:31] dbus_i,
  input  logic        be_lsb_i,
  input  logic        rnw_i,
  input  logic        select_i,
  output logic [1:0]  offset_o,
  output logic        rnw_o,
  output logic [31:0] wdata_o,
  output logic        be_lsb_o,
  output logic        commit_o,
  output logic        ack_o
);

  bus_state_e  state_q, state_d;
  logic [1:0]  offset_q;
  logic        rnw_q;
  logic [31:0] wdata_q;
  logic        be_lsb_q;
  logic        hit;

  assign hit = select_i && (abus_i >= C_BASEADDR) && (abus_i <= C_HIGHADDR);

  // Transfer attributes are captured on the edge entering DECODE so that
  // they are stable for the whole DECODE cycle in which the register file
  // builds the read word and commits writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= BUS_IDLE;
      offset_q <= 2'd0;
      rnw_q    <= 1'b0;
      wdata_q  <= 32'd0;
      be_lsb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == BUS_IDLE && hit) begin
        offset_q <= abus_i[28:29];
        rnw_q    <= rnw_i;
        wdata_q  <= dbus_i;
        be_lsb_q <= be_lsb_i;
      end
    end
  end

  // HOLD exits unconditionally; the extra cycle keeps a master that is slow
  // to drop OPB_select from being acknowledged twice.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUS_IDLE:   if (hit) state_d = BUS_DECODE;
      BUS_DECODE: state_d = BUS_ACK;
      BUS_ACK:    state_d = BUS_HOLD;
      BUS_HOLD:   state_d = BUS_IDLE;
      default:    state_d = BUS_IDLE;
    endcase
  end

  assign offset_o = offset_q;
  assign rnw_o    = rnw_q;
  assign wdata_o  = wdata_q;
  assign be_lsb_o = be_lsb_q;
  assign commit_o = (state_q == BUS_DECODE);
  assign ack_o    = (state_q == BUS_ACK);

endmodule

// File: rtl/opb_register_simulink2ppc_status.sv
// rtl/opb_register_simulink2ppc_status.sv - Fabric-to-PPC status register with OPB read-back
// Purpose: captures a fabric word on user_data_valid, tracks NEW/OVF status and
// a capture count, and serves DATA/STATUS/COUNT to the PowerPC over OPB.
// Ports:
//   OPB_Clk, OPB_Rst_n          clock, asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW        OPB request, big-endian bit numbering
//   OPB_select, OPB_seqAddr     transfer request; seqAddr is ignored
//   Sl_DBus, Sl_xferAck         read data (zero outside the ack cycle), acknowledge
//   Sl_errAck/retry/toutSup     tied low
//   user_data_in, user_data_valid  fabric word and capture strobe
module opb_register_simulink2ppc_status
  import opb_register_simulink2ppc_status_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_1200,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_12FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [31:0] user_data_in,
  input  logic        user_data_valid
);

  localparam int FAMILY_BITS = $bits(C_FAMILY);
  localparam bit PARAMS_OK   = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) && (FAMILY_BITS > 0);

  logic [1:0]  offset;
  logic        rnw;
  logic [31:0] wdata;
  logic        be_lsb;
  logic        commit;
  logic        ack;

  opb_register_simulink2ppc_status_opb_slave_attach #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_attach (
    .clk_i    (OPB_Clk),
    .rst_ni   (OPB_Rst_n),
    .abus_i   (OPB_ABus),
    .dbus_i   (OPB_DBus),
    .be_lsb_i (OPB_BE[3]),
    .rnw_i    (OPB_RNW),
    .select_i (OPB_select),
    .offset_o (offset),
    .rnw_o    (rnw),
    .wdata_o  (wdata),
    .be_lsb_o (be_lsb),
    .commit_o (commit),
    .ack_o    (ack)
  );

  logic [31:0] data_q, data_d;
  logic        new_q, new_d;
  logic        ovf_q, ovf_d;
  logic [31:0] count_q, count_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] status_word;
  logic        rd_commit, wr_commit;
  logic        new_clr, ovf_clr, count_clr;

  assign rd_commit = commit && rnw;
  assign wr_commit = commit && !rnw;

  assign new_clr   = (rd_commit && offset == REG_DATA) ||
                     (wr_commit && offset == REG_STATUS && be_lsb && wdata[STATUS_NEW_BIT]);
  assign ovf_clr   = wr_commit && offset == REG_STATUS && be_lsb && wdata[STATUS_OVF_BIT];
  assign count_clr = wr_commit && offset == REG_COUNT;

  always_comb begin
    status_word                 = 32'd0;
    status_word[STATUS_NEW_BIT] = new_q;
    status_word[STATUS_OVF_BIT] = ovf_q;
  end

  // Clears are applied first and a same-edge capture then overrides them:
  // NEW ends set, COUNT restarts at 1, and OVF is only forced when the
  // pre-edge NEW was already set.
  always_comb begin
    data_d  = data_q;
    new_d   = new_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    rdata_d = rdata_q;
    if (new_clr)   new_d   = 1'b0;
    if (ovf_clr)   ovf_d   = 1'b0;
    if (count_clr) count_d = 32'd0;
    if (user_data_valid) begin
      data_d  = user_data_in;
      new_d   = 1'b1;
      if (new_q) ovf_d = 1'b1;
      count_d = count_d + 32'd1;
    end
    // Read word is built from the pre-edge register values, so a capture
    // landing on the same edge is not visible in this transfer.
    if (commit) begin
      unique case (offset)
        REG_DATA:   rdata_d = data_q;
        REG_STATUS: rdata_d = status_word;
        REG_COUNT:  rdata_d = count_q;
        REG_RSVD:   rdata_d = 32'd0;
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q  <= 32'd0;
      new_q   <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      data_q  <= data_d;
      new_q   <= new_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

  // Numeric bit 31 lands on Sl_DBus[0]
  assign Sl_DBus    = ack ? rdata_q : 32'd0;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:2], PARAMS_OK};

endmodule

// File: tb/tb_opb_register_simulink2ppc_status.sv
// tb/tb_opb_register_simulink2ppc_status.sv - Scoreboard bench for opb_register_simulink2ppc_status
module tb_opb_register_simulink2ppc_status;

  localparam logic [31:0] BASE = 32'h0100_1200;
  localparam logic [31:0] HIGH = 32'h0100_12FF;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst_n;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_in;
  logic        user_data_valid;

  always #5 OPB_Clk = ~OPB_Clk;

  opb_register_simulink2ppc_status #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH),
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_FAMILY     ("virtex5")
  ) dut (
    .OPB_Clk         (OPB_Clk),
    .OPB_Rst_n       (OPB_Rst_n),
    .OPB_ABus        (OPB_ABus),
    .OPB_BE          (OPB_BE),
    .OPB_DBus        (OPB_DBus),
    .OPB_RNW         (OPB_RNW),
    .OPB_select      (OPB_select),
    .OPB_seqAddr     (OPB_seqAddr),
    .Sl_DBus         (Sl_DBus),
    .Sl_xferAck      (Sl_xferAck),
    .Sl_errAck       (Sl_errAck),
    .Sl_retry        (Sl_retry),
    .Sl_toutSup      (Sl_toutSup),
    .user_data_in    (user_data_in),
    .user_data_valid (user_data_valid)
  );

  typedef struct {
    bit          rnw;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %h want %h", name, got, want);
  endtask

  // Monitor: every acknowledge pops one expectation; reads compare Sl_DBus.
  initial begin
    exp_t e;
    forever begin
      @(negedge OPB_Clk);
      if (Sl_xferAck === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          if (e.rnw) check(e.name, Sl_DBus, e.data);
        end
      end
    end
  end

  task automatic capture(input logic [31:0] d);
    @(negedge OPB_Clk);
    user_data_valid = 1'b1;
    user_data_in    = d;
    @(negedge OPB_Clk);
    user_data_valid = 1'b0;
  endtask

  // mode 0: plain; 1: capture cap during DECODE; 2: reset during DECODE
  task automatic xfer(input string name, input bit rnw, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input bit exp_ack,
                      input logic [31:0] exp_rd, input int mode, input logic [31:0] cap);
    int ack_at;
    int ack_cnt;
    bit dbus_bad;
    exp_t e;
    ack_at   = -1;
    ack_cnt  = 0;
    dbus_bad = 1'b0;
    @(negedge OPB_Clk);
    OPB_select = 1'b1;
    OPB_ABus   = addr;
    OPB_RNW    = rnw;
    OPB_BE     = be;
    OPB_DBus   = wd;
    if (exp_ack) begin
      e.rnw  = rnw;
      e.data = exp_rd;
      e.name = name;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge OPB_Clk);
      if (k == 1 && mode == 1) begin
        user_data_valid = 1'b1;
        user_data_in    = cap;
      end else begin
        user_data_valid = 1'b0;
      end
      if (k == 1 && mode == 2) begin
        OPB_Rst_n  = 1'b0;
        OPB_select = 1'b0;
      end
      if (k == 3 && mode == 2) OPB_Rst_n = 1'b1;
      if (Sl_xferAck === 1'b1) begin
        ack_cnt++;
        if (ack_at < 0) ack_at = k;
        OPB_select = 1'b0;
      end else if (Sl_DBus !== 32'd0) begin
        dbus_bad = 1'b1;
      end
    end
    OPB_select = 1'b0;
    check({name, "_ackcnt"}, ack_cnt, exp_ack ? 32'd1 : 32'd0);
    if (exp_ack) check({name, "_acklat"}, ack_at, 32'd2);
    check({name, "_dbus_idle"}, {31'd0, dbus_bad}, 32'd0);
  endtask

  task automatic rd(input string name, input logic [7:0] off, input logic [31:0] want);
    xfer(name, 1'b1, BASE + {24'd0, off}, 4'hF, 32'd0, 1'b1, want, 0, 32'd0);
  endtask

  task automatic wr(input string name, input logic [7:0] off, input logic [3:0] be, input logic [31:0] wd);
    xfer(name, 1'b0, BASE + {24'd0, off}, be, wd, 1'b1, 32'd0, 0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    OPB_Rst_n       = 1'b0;
    OPB_ABus        = 32'd0;
    OPB_BE          = 4'h0;
    OPB_DBus        = 32'd0;
    OPB_RNW         = 1'b0;
    OPB_select      = 1'b0;
    OPB_seqAddr     = 1'b0;
    user_data_in    = 32'd0;
    user_data_valid = 1'b0;
    repeat (3) @(negedge OPB_Clk);
    check("rst_ack", {31'd0, Sl_xferAck}, 32'd0);
    check("rst_dbus", Sl_DBus, 32'd0);
    OPB_Rst_n = 1'b1;

    rd("rst_data", 8'h00, 32'h0);
    rd("rst_status", 8'h04, 32'h0);
    rd("rst_count", 8'h08, 32'h0);

    capture(32'hDEADBEEF);
    rd("cap_status", 8'h04, 32'h1);
    rd("cap_data", 8'h00, 32'hDEADBEEF);
    rd("cap_status_clr", 8'h04, 32'h0);
    rd("cap_count", 8'h08, 32'h1);

    capture(32'h1);
    capture(32'h2);
    rd("ovf_status", 8'h04, 32'h3);
    wr("ovf_clr_wr", 8'h04, 4'b1111, 32'h2);
    rd("ovf_clr_status", 8'h04, 32'h1);
    capture(32'h5);
    rd("ovf_set_again", 8'h04, 32'h3);
    wr("be_off_wr", 8'h04, 4'b1110, 32'h3);
    rd("be_off_status", 8'h04, 32'h3);
    wr("both_clr_wr", 8'h04, 4'b1111, 32'h3);
    rd("both_clr_status", 8'h04, 32'h0);
    rd("data_after", 8'h00, 32'h5);
    wr("data_wr", 8'h00, 4'b1111, 32'hFFFFFFFF);
    rd("data_ro", 8'h00, 32'h5);
    rd("rsvd", 8'h0C, 32'h0);
    wr("rsvd_wr", 8'h0C, 4'b1111, 32'hFFFFFFFF);
    rd("count_4", 8'h08, 32'h4);

    xfer("race_data", 1'b1, BASE, 4'hF, 32'd0, 1'b1, 32'h5, 1, 32'h12345678);
    rd("race_status", 8'h04, 32'h1);
    rd("race_data_new", 8'h00, 32'h12345678);
    rd("count_5", 8'h08, 32'h5);
    wr("count_wr", 8'h08, 4'b0000, 32'h0);
    rd("count_cleared", 8'h08, 32'h0);

    // Preload COUNT to all-ones rather than spending 2^32 captures.
    @(negedge OPB_Clk);
    force dut.count_q = 32'hFFFFFFFF;
    repeat (2) @(negedge OPB_Clk);
    release dut.count_q;
    xfer("cnt_race_wr", 1'b0, BASE + 32'h8, 4'hF, 32'd0, 1'b1, 32'd0, 1, 32'hA5A5A5A5);
    rd("cnt_race", 8'h08, 32'h1);

    @(negedge OPB_Clk);
    force dut.count_q = 32'hFFFFFFFF;
    repeat (2) @(negedge OPB_Clk);
    release dut.count_q;
    capture(32'h0BADF00D);
    rd("cnt_wrap", 8'h08, 32'h0);
    rd("wrap_status", 8'h04, 32'h3);

    xfer("miss_high", 1'b1, HIGH + 32'h4, 4'hF, 32'd0, 1'b0, 32'd0, 0, 32'd0);
    xfer("miss_low", 1'b1, BASE - 32'h4, 4'hF, 32'd0, 1'b0, 32'd0, 0, 32'd0);

    capture(32'h00000077);
    xfer("rst_mid", 1'b1, BASE, 4'hF, 32'd0, 1'b0, 32'd0, 2, 32'd0);
    rd("rst_mid_data", 8'h00, 32'h0);
    rd("rst_mid_status", 8'h04, 32'h0);
    rd("rst_mid_count", 8'h08, 32'h0);

    repeat (2) @(negedge OPB_Clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
